freq_div_ctrl: RTL

Programmable clock-enable frequency divider controller. It generates a divide-by-N square wave (`frequency`) and a one-cycle `tick` at the start of each output period. It sequences run/stop so output periods are never truncated. New divisors are loaded through a valid/ready handshake and take effect only at period boundaries, giving glitch-free ratio changes. It replaces fixed divide-by-2 flip-flop chains wherever a runtime-selectable ratio is needed.

---
 rtl/freq_div_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/freq_div_ctrl.sv
// Programmable clock-enable frequency divider: divide-by-N square wave plus period tick,
// with run/stop sequencing and glitch-free divisor changes at period boundaries.
module freq_div_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             frequency,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] active_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             freq_q, freq_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;

  logic             xfer;
  logic             div_bad;
  logic             div_ok;
  logic             wrap;
  logic             load_pend;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] high_n;

  assign xfer    = cfg_valid & cfg_ready_q;
  assign div_bad = (cfg_div < WIDTH'(2));
  assign div_ok  = xfer & ~div_bad;
  assign cnt_inc = cnt_q + WIDTH'(1);
  assign high_n  = active_div_q - (active_div_q >> 1);
  assign wrap    = (state_q != IDLE) && (cnt_q == (active_div_q - WIDTH'(1)));

  // Next-state, counter and divisor bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    tick_d       = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    active_div_d = active_div_q;
    load_pend    = 1'b0;
    cfg_err_d    = xfer & div_bad;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        freq_d = 1'b0;
        if (div_ok) begin
          active_div_d = cfg_div;
        end
        if (enable) begin
          state_d = RUN;
          freq_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOP: begin
        if (wrap) begin
          // A write landing on the wrap edge governs the period starting here
          if (pend_valid_q) begin
            active_div_d = pend_div_q;
            pend_valid_d = 1'b0;
            load_pend    = 1'b1;
          end else if (div_ok) begin
            active_div_d = cfg_div;
          end
          cnt_d = '0;
          if ((state_q == RUN) && enable) begin
            freq_d = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
            freq_d  = 1'b0;
          end
        end else begin
          cnt_d   = cnt_inc;
          freq_d  = (cnt_inc < high_n);
          state_d = enable ? RUN : STOP;
          if (div_ok) begin
            pend_valid_d = 1'b1;
            pend_div_d   = cfg_div;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        freq_d  = 1'b0;
      end
    endcase

    // Ready reopens one cycle after a pending divisor is consumed
    cfg_ready_d = ~pend_valid_d & ~load_pend;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      active_div_q <= WIDTH'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      freq_q       <= 1'b0;
      tick_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      freq_q       <= freq_d;
      tick_q       <= tick_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign frequency  = freq_q;
  assign tick       = tick_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_ready  = cfg_ready_q;
  assign busy       = busy_q;
  assign active_div = active_div_q;

endmodule
